// File: rtl/pe_row_psum_collector_if.sv
// Handshake and payload bundle between the PE row producer, the psum
// collector and the writeback consumer.
//   mode/acc_len/shift : group configuration (sampled on a group's first beat)
//   in_valid/in_ready  : product beat handshake
//   product            : LANES x 16-bit signed per-lane products
//   out_valid/out_ready: result handshake
//   out_psum/out_q/out_sat : group sum, int8 requantized value, clip flag
interface pe_row_psum_collector_if #(
    parameter int unsigned LANES = 16,
    parameter int unsigned ACC_W = 32,
    parameter int unsigned CNT_W = 8
);
    logic [1:0]                 mode;
    logic [CNT_W-1:0]           acc_len;
    logic [4:0]                 shift;
    logic                       in_valid;
    logic                       in_ready;
    logic [LANES-1:0][15:0]     product;
    logic                       out_valid;
    logic                       out_ready;
    logic signed [ACC_W-1:0]    out_psum;
    logic signed [7:0]          out_q;
    logic                       out_sat;

    // Producer/consumer side (drives beats, accepts results).
    modport master (
        output mode, acc_len, shift, in_valid, product, out_ready,
        input  in_ready, out_valid, out_psum, out_q, out_sat
    );

    // Collector side.
    modport slave (
        input  mode, acc_len, shift, in_valid, product, out_ready,
        output in_ready, out_valid, out_psum, out_q, out_sat
    );
endinterface

// File: rtl/pe_row_psum_collector.sv
// Cross-lane reduction of PE row products, accumulated over a programmable
// number of beats, emitted as a 32-bit partial sum plus an int8 requantized
// value.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : slave view of pe_row_psum_collector_if (beat in, result out)
// Pipeline: stage 1 registers the masked lane sum, stage 2 accumulates and
// loads the output registers on the group's last beat. A held result
// (out_valid & ~out_ready) freezes both stages.
module pe_row_psum_collector #(
    parameter int unsigned LANES = 16,
    parameter int unsigned ACC_W = 32,
    parameter int unsigned CNT_W = 8
) (
    input  logic clk,
    input  logic rst,
    pe_row_psum_collector_if.slave bus
);
    localparam int unsigned S1_W = 20;
    localparam int unsigned Q_W  = 8;
    localparam logic signed [ACC_W-1:0] Q_MAX = ACC_W'(127);
    localparam logic signed [ACC_W-1:0] Q_MIN = ACC_W'(-128);

    logic                    stall;
    logic                    accept;

    logic [CNT_W-1:0]        beat_cnt;
    logic [1:0]              cfg_mode;
    logic [CNT_W-1:0]        cfg_len;
    logic [4:0]              cfg_shift;

    logic                    first_beat;
    logic [1:0]              cur_mode;
    logic [CNT_W-1:0]        cur_len;
    logic [CNT_W-1:0]        eff_len;
    logic                    last_beat;
    logic signed [S1_W-1:0]  lane_sum;

    logic                    s1_valid;
    logic                    s1_last;
    logic signed [S1_W-1:0]  s1_sum;

    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] acc_next;
    logic signed [ACC_W-1:0] shifted;
    logic signed [Q_W-1:0]   q_next;
    logic                    sat_next;

    logic                    out_valid_r;
    logic signed [ACC_W-1:0] out_psum_r;
    logic signed [Q_W-1:0]   out_q_r;
    logic                    out_sat_r;

    assign stall  = out_valid_r & ~bus.out_ready;
    assign accept = bus.in_valid & ~stall;

    assign bus.in_ready  = ~stall;
    assign bus.out_valid = out_valid_r;
    assign bus.out_psum  = out_psum_r;
    assign bus.out_q     = out_q_r;
    assign bus.out_sat   = out_sat_r;

    // The first beat of a group uses the live config; later beats use the latched copy.
    assign first_beat = (beat_cnt == '0);
    assign cur_mode   = first_beat ? bus.mode    : cfg_mode;
    assign cur_len    = first_beat ? bus.acc_len : cfg_len;
    assign eff_len    = (cur_len == '0) ? CNT_W'(1) : cur_len;
    assign last_beat  = (beat_cnt == eff_len - CNT_W'(1));

    // Masked cross-lane sum; mode 1 keeps lanes 0..2 only.
    always_comb begin
        lane_sum = '0;
        for (int i = 0; i < int'(LANES); i++) begin
            if (cur_mode != 2'd1 || i < 3) begin
                lane_sum = lane_sum + S1_W'($signed(bus.product[i]));
            end
        end
    end

    // Accumulate and requantize with the shift latched for the group in flight.
    always_comb begin
        acc_next = acc + ACC_W'(s1_sum);
        shifted  = acc_next >>> cfg_shift;
        q_next   = shifted[Q_W-1:0];
        sat_next = 1'b0;
        if (shifted > Q_MAX) begin
            q_next   = Q_W'(127);
            sat_next = 1'b1;
        end else if (shifted < Q_MIN) begin
            q_next   = Q_W'(-128);
            sat_next = 1'b1;
        end
    end

    // Both pipeline stages and the output registers; all hold during stall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_cnt    <= '0;
            cfg_mode    <= '0;
            cfg_len     <= '0;
            cfg_shift   <= '0;
            s1_valid    <= 1'b0;
            s1_last     <= 1'b0;
            s1_sum      <= '0;
            acc         <= '0;
            out_valid_r <= 1'b0;
            out_psum_r  <= '0;
            out_q_r     <= '0;
            out_sat_r   <= 1'b0;
        end else if (!stall) begin
            s1_valid <= accept;
            if (accept) begin
                s1_sum   <= lane_sum;
                s1_last  <= last_beat;
                beat_cnt <= last_beat ? '0 : beat_cnt + CNT_W'(1);
                if (first_beat) begin
                    cfg_mode  <= bus.mode;
                    cfg_len   <= bus.acc_len;
                    cfg_shift <= bus.shift;
                end
            end
            // Not stalled means any held result is retiring this cycle.
            out_valid_r <= s1_valid & s1_last;
            if (s1_valid) begin
                if (s1_last) begin
                    out_psum_r <= acc_next;
                    out_q_r    <= q_next;
                    out_sat_r  <= sat_next;
                    acc        <= '0;
                end else begin
                    acc <= acc_next;
                end
            end
        end
    end
endmodule

// File: doc/pe_row_psum_collector.md
Name: pe_row_psum_collector

Overview:
- Downstream consumer of a 16-lane PE row. Takes the per-lane signed 16-bit products each accepted beat and reduces them across lanes.
- Accumulates the lane sums over a programmable number of beats, then emits one 32-bit partial sum plus an int8 requantized value through a valid/ready handshake.
- Sits between the PE row outputs and the output buffer / writeback path of the DLA.

Parameters:
- LANES, 16, number of product lanes (matches PE row width)
- ACC_W, 32, accumulator and out_psum width
- CNT_W, 8, width of acc_len and of the beat counter

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- mode  in  2  2'd1: sum lanes 0..2 only; 2'd0/2'd2/2'd3: sum all LANES
- acc_len  in  CNT_W  beats per output group; 0 treated as 1
- shift  in  5  arithmetic right shift applied before int8 saturation
- in_valid  in  1  product beat valid
- in_ready  out  1  collector can accept a beat
- product  in  LANES x 16 (signed)  per-lane products
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_psum  out  ACC_W (signed)  accumulated group sum
- out_q  out  8 (signed)  sat(out_psum >>> shift) to [-128, 127]
- out_sat  out  1  out_q was clipped

Behaviour:
- Reset: in_ready=1, out_valid=0, out_psum=0, out_q=0, out_sat=0. Beat counter, accumulator, stage-1 valid and latched config are all cleared.
- stall = out_valid & ~out_ready. in_ready = ~stall. When stall=1 all pipeline registers hold.
- Accept a beat when in_valid & in_ready.
- Config latch: mode, acc_len and shift are latched on the first beat of a group (beat_cnt==0). Changes mid-group have no effect until the next group.
- Stage 1 (on accept):
  - s1_sum = sign-extended sum of the masked lanes, 20 bits.
  - s1_valid <= 1.
  - s1_last <= (beat_cnt == eff_len-1), where eff_len = max(acc_len,1).
  - beat_cnt increments, wrapping to 0 after the last beat.
- Stage 1, no accept and no stall: s1_valid <= 0.
- Stage 2 (s1_valid & ~stall):
  - acc_next = acc + sext(s1_sum).
  - If s1_last: out_psum <= acc_next, out_q/out_sat computed from acc_next with the latched shift, out_valid <= 1, acc <= 0.
  - Otherwise: acc <= acc_next.
- Output retire: out_valid falls on out_valid & out_ready unless a new result is loaded in the same cycle; in that case out_valid stays 1 with the new data.
- Latency: last beat accepted at cycle t → out_valid at t+2. Sustained throughput is one beat per cycle while out_ready=1.
- Width: worst case |sum| = 16·2^15 per beat, times 255 beats < 2^31, so ACC_W=32 never overflows. No wrap handling is required.
- Requantize: y = out_psum >>> shift (sign-preserving, truncation toward −∞).
  - y > 127 → out_q=127, out_sat=1.
  - y < −128 → out_q=−128, out_sat=1.
  - Otherwise out_q = y[7:0], out_sat=0.
- Outputs out_psum/out_q/out_sat are stable while out_valid & ~out_ready.
- Reset mid-group: partial accumulation is discarded. The first beat after reset starts a new group.
- in_valid with in_ready=0: the beat is not consumed and the upstream holds product.

Test Plan:
- mode=0, acc_len=1, shift=0, every lane=1, one beat at t → out_valid at t+2, out_psum=16, out_q=16, out_sat=0.
- mode=0, acc_len=4, shift=2, lane i = i−8 (beat sum −8), 4 back-to-back beats → single result out_psum=−32, out_q=−8. Verify no out_valid after beats 1–3.
- mode=1, acc_len=1, shift=0, lanes 0..2=100, lanes 3..15=1000 → out_psum=300, out_q=127, out_sat=1.
- out_ready=0, stream two groups of acc_len=2 (beat sums 5 and 7 per group) → in_ready drops while the first result is held. Raise out_ready → results 10 then 14 in order; no beat lost or duplicated.
- acc_len=255, mode=0, all lanes=−32768 for 255 beats, shift=0 → out_psum=−133693440, out_q=−128, out_sat=1. Then acc_len=0 with lanes=2 → out_psum=32 after one beat.
- Assert rst after 2 of 4 beats, release, send 4 beats of sum 3 → out_psum=12 with no residue from the aborted group. All outputs are at reset values during rst.
